// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and width helper
//
// Purpose: common definitions for uart_tx and uart_rx.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Width needed to count 0..n-1; never returns 0 so degenerate
  // parameters still yield a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous input
//
// Purpose: bring an asynchronous single-bit signal into the clk domain.
// Ports:
//   clk    - destination clock, rising edge
//   rst_n  - asynchronous active-low reset; both flops load RESET_VAL
//   d      - asynchronous input
//   q      - synchronized output (second flop)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1-style framing with mid-bit sampling
//
// Purpose: receive 1 start bit, DATA_BITS data bits (LSB first) and 1 stop
// bit from an asynchronous serial line; strobe good words and framing errors.
// Ports:
//   i_Clock        - system clock, rising edge
//   i_Rst_n        - asynchronous active-low reset
//   i_Rx_Serial    - asynchronous serial line, idles high
//   o_Rx_DV        - one-cycle strobe, o_Rx_Data valid with a good stop bit
//   o_Rx_Data      - last received word, held until the next good frame
//   o_Rx_Frame_Err - one-cycle strobe when the stop bit samples low
//   o_Rx_Active    - high while a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Active
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, ferr_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      // Re-check the line at mid start bit; a pulse shorter than half a
      // bit is treated as noise and dropped silently.
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counting from mid start bit, each full bit period lands mid-bit.
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid stop bit leaves half a bit of margin to catch a
      // start bit that follows with no idle gap.
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must not be seen as a stream of start bits.
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Data      = data_q;
  assign o_Rx_Active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int CPB_A = 8;
  localparam int CPB_B = 16;
  localparam int CPB_C = 5;
  localparam int NB_C  = 16;
  // Start edge to DV: sync, mid start bit, data bits, then the stop bit is
  // sampled mid-bit one further bit period later, plus the output register.
  localparam int LAT_C = 2 + (CPB_C - 1) / 2 + 1 + NB_C * CPB_C + 1 + CPB_C;

  typedef struct packed {
    logic [1:0]  k;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  logic [2:0] rx_line = 3'b111;

  logic        dv_a, err_a, act_a;
  logic [7:0]  data_a;
  logic        dv_b, err_b, act_b;
  logic [7:0]  data_b;
  logic        dv_c, err_c, act_c;
  logic [15:0] data_c;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   edge_cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n[0]), .i_Rx_Serial(rx_line[0]),
    .o_Rx_DV(dv_a), .o_Rx_Data(data_a), .o_Rx_Frame_Err(err_a), .o_Rx_Active(act_a));

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n[1]), .i_Rx_Serial(rx_line[1]),
    .o_Rx_DV(dv_b), .o_Rx_Data(data_b), .o_Rx_Frame_Err(err_b), .o_Rx_Active(act_b));

  uart_rx #(.CLKS_PER_BIT(CPB_C), .DATA_BITS(NB_C)) dut_c (
    .i_Clock(clk), .i_Rst_n(rst_n[2]), .i_Rx_Serial(rx_line[2]),
    .o_Rx_DV(dv_c), .o_Rx_Data(data_c), .o_Rx_Frame_Err(err_c), .o_Rx_Active(act_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int k, input logic err, input logic [31:0] d);
    exp_t e;
    e.k    = 2'(k);
    e.err  = err;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Drives one frame, each bit held cpb cycles; the line is left at the
  // stop-bit value on return. Called aligned to a falling clock edge.
  task automatic send_frame(input int k, input logic [31:0] d, input int nbits,
                            input int cpb, input logic stop);
    rx_line[k] = 1'b0;
    if (k == 2) edge_cyc = cyc;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_line[k] = d[i];
      repeat (cpb) @(negedge clk);
    end
    rx_line[k] = stop;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic mon_one(input int k, input logic dv, input logic err,
                         input logic [31:0] data, input logic act);
    exp_t e;
    if (dv || err) begin
      check($sformatf("strobes_exclusive_%0d", k), {31'd0, dv & err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe dut%0d: dv=%0d err=%0d data=0x%0h expected no strobe",
                 k, dv, err, data);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("strobe_dut_%0d", k), k, {30'd0, e.k});
        check($sformatf("strobe_kind_dut%0d", k), {31'd0, err}, {31'd0, e.err});
        check($sformatf("rx_data_dut%0d", k), data, e.data);
        check($sformatf("active_at_strobe_dut%0d", k), {31'd0, act}, {31'd0, err});
        if (k == 2 && dv) begin
          n_checks++;
          if ((cyc - edge_cyc) < LAT_C - 1 || (cyc - edge_cyc) > LAT_C + 1) begin
            n_fail++;
            $display("FAIL dv_latency: got %0d cycles expected %0d +/-1", cyc - edge_cyc, LAT_C);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, dv_a, err_a, {24'd0, data_a}, act_a);
    mon_one(1, dv_b, err_b, {24'd0, data_b}, act_b);
    mon_one(2, dv_c, err_c, {16'd0, data_c}, act_c);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_dv", {31'd0, dv_a}, 32'd0);
    check("reset_err", {31'd0, err_a}, 32'd0);
    check("reset_active", {31'd0, act_a}, 32'd0);
    check("reset_data", {24'd0, data_a}, 32'd0);
    check("reset_data_c", {16'd0, data_c}, 32'd0);
    rst_n = 3'b111;
    repeat (4) @(negedge clk);

    // 1: single frame
    expect_word(0, 1'b0, 32'hA5);
    send_frame(0, 32'hA5, 8, CPB_A, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);

    // 2: back-to-back frames, no idle gap
    expect_word(0, 1'b0, 32'h00);
    expect_word(0, 1'b0, 32'hFF);
    expect_word(0, 1'b0, 32'h3C);
    send_frame(0, 32'h00, 8, CPB_A, 1'b1);
    send_frame(0, 32'hFF, 8, CPB_A, 1'b1);
    send_frame(0, 32'h3C, 8, CPB_A, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);

    // 3: two-clock glitch then a real frame
    rx_line[1] = 1'b0;
    repeat (2) @(negedge clk);
    rx_line[1] = 1'b1;
    repeat (CPB_B + 4) @(negedge clk);
    check("glitch_active", {31'd0, act_b}, 32'd0);
    expect_word(1, 1'b0, 32'h5A);
    send_frame(1, 32'h5A, 8, CPB_B, 1'b1);
    repeat (2 * CPB_B) @(negedge clk);

    // 4: bad stop bit, line held low 40 bit-times; data keeps 0x3C
    expect_word(0, 1'b1, 32'h3C);
    send_frame(0, 32'h81, 8, CPB_A, 1'b0);
    repeat (20 * CPB_A) @(negedge clk);
    check("break_active", {31'd0, act_a}, 32'd1);
    check("break_data_held", {24'd0, data_a}, 32'h3C);
    repeat (20 * CPB_A) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("break_release_active", {31'd0, act_a}, 32'd0);
    expect_word(0, 1'b0, 32'h42);
    send_frame(0, 32'h42, 8, CPB_A, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);

    // 5: reset during data bit 4 of 0x77
    rx_line[0] = 1'b0;
    repeat (CPB_A) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line[0] = 1'(8'h77 >> i);
      repeat (CPB_A) @(negedge clk);
    end
    rx_line[0] = 1'b1;
    repeat (CPB_A / 2) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midreset_dv", {31'd0, dv_a}, 32'd0);
    check("midreset_err", {31'd0, err_a}, 32'd0);
    check("midreset_active", {31'd0, act_a}, 32'd0);
    check("midreset_data", {24'd0, data_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_active", {31'd0, act_a}, 32'd0);
    expect_word(0, 1'b0, 32'h19);
    send_frame(0, 32'h19, 8, CPB_A, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);

    // 6: 16-bit word at 5 clocks per bit, latency checked by the monitor
    expect_word(2, 1'b0, 32'hBEEF);
    send_frame(2, 32'hBEEF, NB_C, CPB_C, 1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
